// File: rtl/vedicmult_pipe_if.sv
// ----------------------------------------------------------------------------
// vedicmult_pipe_if
// Handshake and data bundle for the pipelined Vedic multiplier.
//   Parameters : WIDTH     operand width in bits (4, 8, 16 or 32)
//   Signals    : in_valid  operand transaction present        (master -> slave)
//                in_ready  multiplier accepts this cycle      (slave  -> master)
//                a, b      multiplicand / multiplier          (master -> slave)
//                is_signed 1 = two's complement operands      (master -> slave)
//                out_valid product present on out_p          (slave  -> master)
//                out_ready downstream accepts the product     (master -> slave)
//                out_p     2*WIDTH-bit product                (slave  -> master)
//   Modports   : master (stimulus / consumer side), slave (multiplier side)
// ----------------------------------------------------------------------------
interface vedicmult_pipe_if #(
   parameter int WIDTH = 8
);
   localparam int RESULT_W = 2 * WIDTH;

   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                is_signed;
   logic                out_valid;
   logic                out_ready;
   logic [RESULT_W-1:0] out_p;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/vedicmult_pipe.sv
// ----------------------------------------------------------------------------
// vedicmult_pipe
// Three-stage pipelined signed/unsigned multiplier built from Vedic
// (Urdhva-Tiryagbhyam) cells.
//   S1 : operand capture, magnitude conversion, product sign flag
//   S2 : four registered half-width Vedic partial products
//   S3 : carry-lookahead combine, conditional negate, registered product
// A transaction accepted on one edge has its product on out_p (out_valid = 1)
// in the third cycle after the accept cycle. The whole pipe freezes while the
// output is held (out_valid && !out_ready); bubbles advance like data.
//   Parameters : WIDTH     operand width (4, 8, 16 or 32)
//                RESULT_W  product width, fixed at 2*WIDTH
//   Ports      : clk       rising-edge clock
//                rst       asynchronous active-high reset
//                bus       vedicmult_pipe_if slave (handshake, operands, product)
// ----------------------------------------------------------------------------
module vedicmult_pipe #(
   parameter  int WIDTH    = 8,
   localparam int RESULT_W = 2 * WIDTH
) (
   input logic             clk,
   input logic             rst,
   vedicmult_pipe_if.slave bus
);

   localparam int HALF   = WIDTH / 2;
   // Number of 2-bit digits in a half-width operand and the recursion depth
   // needed to grow 2x2 cells up to a HALF x HALF product.
   localparam int DIGITS = (HALF / 2 < 1) ? 1 : HALF / 2;
   localparam int LEVELS = $clog2(DIGITS);

   if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
      $error("vedicmult_pipe: WIDTH must be 4, 8, 16 or 32");
   end

   // -------------------------------------------------------------------------
   // Arithmetic helpers
   // -------------------------------------------------------------------------

   // 2x2 Vedic cell: vertical and crosswise bit products.
   function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic p00, p01, p10, p11, c1;
      p00 = x[0] & y[0];
      p10 = x[1] & y[0];
      p01 = x[0] & y[1];
      p11 = x[1] & y[1];
      c1  = p10 & p01;
      return {p11 & c1, p11 ^ c1, p10 ^ p01, p00};
   endfunction

   // HALF x HALF Vedic multiply. The recursive construction is unrolled level
   // by level: each level merges 2x2 blocks of sub-products (low, two cross
   // terms, high) into one product of twice the operand width.
   function automatic logic [WIDTH-1:0] vedic_mul(input logic [HALF-1:0] x,
                                                  input logic [HALF-1:0] y);
      logic [WIDTH-1:0] cur [DIGITS][DIGITS];
      logic [WIDTH-1:0] nxt [DIGITS][DIGITS];
      for (int i = 0; i < DIGITS; i++) begin
         for (int j = 0; j < DIGITS; j++) begin
            cur[i][j] = WIDTH'(vedic2x2(x[2*i +: 2], y[2*j +: 2]));
         end
      end
      for (int lvl = 1; lvl <= LEVELS; lvl++) begin
         nxt = cur;
         // Sub-products at this level have operands (1 << lvl) bits wide.
         for (int i = 0; i < (DIGITS >> lvl); i++) begin
            for (int j = 0; j < (DIGITS >> lvl); j++) begin
               nxt[i][j] = cur[2*i][2*j]
                         + ((cur[2*i+1][2*j] + cur[2*i][2*j+1]) << (1 << lvl))
                         + (cur[2*i+1][2*j+1] << (2 << lvl));
            end
         end
         cur = nxt;
      end
      return cur[0][0];
   endfunction

   // Parallel-prefix (Kogge-Stone) carry-lookahead adder. The inner loop runs
   // downwards so each g/p update reads the previous level's values.
   function automatic logic [RESULT_W-1:0] cla_add(input logic [RESULT_W-1:0] x,
                                                   input logic [RESULT_W-1:0] y);
      logic [RESULT_W-1:0] g, p;
      g = x & y;
      p = x ^ y;
      for (int d = 1; d < RESULT_W; d = d * 2) begin
         for (int i = RESULT_W - 1; i >= d; i--) begin
            g[i] = g[i] | (p[i] & g[i-d]);
            p[i] = p[i] & p[i-d];
         end
      end
      // Carry into bit i is the group generate of bits [i-1:0].
      return x ^ y ^ (g << 1);
   endfunction

   // -------------------------------------------------------------------------
   // Flow control
   // -------------------------------------------------------------------------
   logic w_stall;
   logic w_adv;

   logic                r_out_valid;
   logic [RESULT_W-1:0] r_out_p;

   assign w_stall      = r_out_valid && !bus.out_ready;
   assign w_adv        = !w_stall;
   assign bus.in_ready = !w_stall;
   assign bus.out_valid = r_out_valid;
   assign bus.out_p     = r_out_p;

   // -------------------------------------------------------------------------
   // S1 next-state: magnitudes and product sign
   // -------------------------------------------------------------------------
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic             w_neg;

   assign w_a_neg = bus.is_signed && bus.a[WIDTH-1];
   assign w_b_neg = bus.is_signed && bus.b[WIDTH-1];
   // -2^(WIDTH-1) maps onto itself, which reads correctly as the unsigned
   // magnitude 2^(WIDTH-1).
   assign w_mag_a = w_a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
   assign w_mag_b = w_b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
   assign w_neg   = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_neg;

   // -------------------------------------------------------------------------
   // S2 next-state: half-width partial products
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] w_pp_ll;
   logic [WIDTH-1:0] w_pp_hl;
   logic [WIDTH-1:0] w_pp_lh;
   logic [WIDTH-1:0] w_pp_hh;

   assign w_pp_ll = vedic_mul(r_s1_a[HALF-1:0],     r_s1_b[HALF-1:0]);
   assign w_pp_hl = vedic_mul(r_s1_a[WIDTH-1:HALF], r_s1_b[HALF-1:0]);
   assign w_pp_lh = vedic_mul(r_s1_a[HALF-1:0],     r_s1_b[WIDTH-1:HALF]);
   assign w_pp_hh = vedic_mul(r_s1_a[WIDTH-1:HALF], r_s1_b[WIDTH-1:HALF]);

   logic             r_s2_vld;
   logic             r_s2_neg;
   logic [WIDTH-1:0] r_pp_ll;
   logic [WIDTH-1:0] r_pp_hl;
   logic [WIDTH-1:0] r_pp_lh;
   logic [WIDTH-1:0] r_pp_hh;

   // -------------------------------------------------------------------------
   // S3 next-state: combine and sign
   // -------------------------------------------------------------------------
   logic [RESULT_W-1:0] w_mid;
   logic [RESULT_W-1:0] w_sum;
   logic [RESULT_W-1:0] w_negv;
   logic [RESULT_W-1:0] w_prod;

   // The low and high partials do not overlap, so they concatenate for free;
   // only the two cross terms at offset HALF need real additions.
   assign w_mid  = cla_add({{HALF{1'b0}}, r_pp_hl, {HALF{1'b0}}},
                           {{HALF{1'b0}}, r_pp_lh, {HALF{1'b0}}});
   assign w_sum  = cla_add({r_pp_hh, r_pp_ll}, w_mid);
   assign w_negv = cla_add(~w_sum, RESULT_W'(1));
   assign w_prod = r_s2_neg ? w_negv : w_sum;

   // -------------------------------------------------------------------------
   // Pipeline registers: every stage moves together or holds together.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld    <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_neg    <= 1'b0;
         r_s2_vld    <= 1'b0;
         r_s2_neg    <= 1'b0;
         r_pp_ll     <= '0;
         r_pp_hl     <= '0;
         r_pp_lh     <= '0;
         r_pp_hh     <= '0;
         r_out_valid <= 1'b0;
         r_out_p     <= '0;
      end else if (w_adv) begin
         r_s1_vld    <= bus.in_valid;
         r_s1_a      <= w_mag_a;
         r_s1_b      <= w_mag_b;
         r_s1_neg    <= w_neg;
         r_s2_vld    <= r_s1_vld;
         r_s2_neg    <= r_s1_neg;
         r_pp_ll     <= w_pp_ll;
         r_pp_hl     <= w_pp_hl;
         r_pp_lh     <= w_pp_lh;
         r_pp_hh     <= w_pp_hh;
         r_out_valid <= r_s2_vld;
         r_out_p     <= w_prod;
      end
   end

endmodule

// File: tb/tb_vedicmult_pipe.sv
// ----------------------------------------------------------------------------
// tb_vedicmult_pipe
// Directed WIDTH=8 vectors (table plus hand sequences for latency, stall and
// reset), and random streams at WIDTH=16 and WIDTH=32 against a plain
// sign-extended 64-bit multiply.
// ----------------------------------------------------------------------------
module tb_vedicmult_pipe;

   localparam int NRAND      = 10000;
   localparam int RAND_LIMIT = 60000;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_r = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   done [2];

   always #5 clk = ~clk;

   vedicmult_pipe_if #(.WIDTH(8)) bus8 ();
   vedicmult_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic vld);
      bus8.a         = a;
      bus8.b         = b;
      bus8.is_signed = sgn;
      bus8.in_valid  = vld;
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic sgn);
      logic [63:0] ax, bx, p;
      ax = {32'd0, a};
      bx = {32'd0, b};
      if (sgn && a[w-1]) ax = ax | ((~64'd0) << w);
      if (sgn && b[w-1]) bx = bx | ((~64'd0) << w);
      p = ax * bx;
      if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
      return p;
   endfunction

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sgn;
      logic [15:0] exp;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   // Stall sequence operands and products
   logic [7:0]  st_a   [4];
   logic [7:0]  st_b   [4];
   logic        st_s   [4];
   logic [15:0] st_exp [4];

   initial begin
      int got;
      int spurious;
      logic acc;

      vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
      vecs[3]  = '{8'h00, 8'hFB, 1'b1, 16'h0000};
      vecs[4]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
      vecs[5]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
      vecs[6]  = '{8'h03, 8'h07, 1'b0, 16'h0015};
      vecs[7]  = '{8'h0F, 8'h11, 1'b0, 16'h00FF};
      vecs[8]  = '{8'hFE, 8'h03, 1'b1, 16'hFFFA};
      vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      vecs[10] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vecs[11] = '{8'h80, 8'h02, 1'b0, 16'h0100};
      vecs[12] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
      vecs[13] = '{8'hC8, 8'h64, 1'b0, 16'h4E20};
      vecs[14] = '{8'h05, 8'hFB, 1'b1, 16'hFFE7};

      st_a = '{8'd3, 8'd10, 8'd200, 8'h80};
      st_b = '{8'd5, 8'd11, 8'd200, 8'h80};
      st_s = '{1'b0, 1'b0, 1'b0, 1'b1};
      st_exp = '{16'h000F, 16'h006E, 16'h9C40, 16'h4000};

      // Reset state, with out_ready low to show in_ready ignores it in reset
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      bus8.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      check("rst_out_p",     64'(bus8.out_p),     64'd0);
      check("rst_in_ready",  64'(bus8.in_ready),  64'd1);

      // Single unsigned 255*255 accepted on the first edge after reset:
      // valid only in the third cycle after accept, one cycle wide.
      @(negedge clk);
      rst   = 1'b0;
      rst_r = 1'b0;
      bus8.out_ready = 1'b1;
      drive(8'hFF, 8'hFF, 1'b0, 1'b1);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 1) bus8.in_valid = 1'b0;
         #1;
         check("lat_out_valid", 64'(bus8.out_valid), (j == 3) ? 64'd1 : 64'd0);
         if (j == 3) check("lat_out_p", 64'(bus8.out_p), 64'hFE01);
      end

      // Back-to-back table: one result per cycle, in order, mixed modes
      for (int j = 0; j < NVEC + 3; j++) begin
         if (j < NVEC) drive(vecs[j].a, vecs[j].b, vecs[j].sgn, 1'b1);
         else          bus8.in_valid = 1'b0;
         @(negedge clk);
         #1;
         if (j >= 2 && j - 2 < NVEC) begin
            check("tbl_out_valid", 64'(bus8.out_valid), 64'd1);
            check($sformatf("tbl_out_p[%0d]", j - 2), 64'(bus8.out_p),
                  64'(vecs[j-2].exp));
         end else begin
            check("tbl_bubble", 64'(bus8.out_valid), 64'd0);
         end
      end

      // Stall: three accepted, fourth offered while output held for 5 cycles
      bus8.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(st_a[k], st_b[k], st_s[k], 1'b1);
         @(negedge clk);
         #1;
      end
      drive(st_a[3], st_b[3], st_s[3], 1'b1);
      for (int s = 0; s < 5; s++) begin
         check("stall_in_ready",  64'(bus8.in_ready),  64'd0);
         check("stall_out_valid", 64'(bus8.out_valid), 64'd1);
         check("stall_out_p",     64'(bus8.out_p),     64'(st_exp[0]));
         @(negedge clk);
         #1;
      end
      bus8.out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (bus8.out_valid) begin
            if (got < 4) check($sformatf("stall_drain[%0d]", got), 64'(bus8.out_p),
                               64'(st_exp[got]));
            got++;
         end
         acc = bus8.in_valid && bus8.in_ready;
         @(negedge clk);
         if (acc) bus8.in_valid = 1'b0;
      end
      check("stall_drain_count", 64'(got), 64'd4);

      // Reset with three transactions in flight
      bus8.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(8'(9 - k), 8'(9 - k), 1'b0, 1'b1);
         @(negedge clk);
      end
      bus8.in_valid = 1'b0;
      #1;
      check("prerst_out_valid", 64'(bus8.out_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(bus8.out_valid), 64'd0);
      check("midrst_out_p",     64'(bus8.out_p),     64'd0);
      check("midrst_in_ready",  64'(bus8.in_ready),  64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus8.out_ready = 1'b1;
      spurious = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         if (bus8.out_valid) spurious++;
      end
      check("postrst_stale_outputs", 64'(spurious), 64'd0);
      drive(8'd3, 8'd7, 1'b0, 1'b1);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 1) bus8.in_valid = 1'b0;
         #1;
         check("postrst_out_valid", 64'(bus8.out_valid), (j == 3) ? 64'd1 : 64'd0);
         if (j == 3) check("postrst_out_p", 64'(bus8.out_p), 64'h0015);
      end

      wait (done[0] && done[1]);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Random streams at WIDTH=16 and WIDTH=32 with random back-pressure
   for (genvar gi = 0; gi < 2; gi++) begin : g_rand
      localparam int W = (gi == 0) ? 16 : 32;

      vedicmult_pipe_if #(.WIDTH(W)) rbus ();
      vedicmult_pipe #(.WIDTH(W)) rdut (.clk(clk), .rst(rst_r), .bus(rbus));

      logic [63:0] expq [$];

      initial begin : rand_proc
         int          sent;
         int          got;
         int          cyc;
         logic        acc;
         logic        con;
         logic [63:0] exp_v;
         string       tag;
         tag  = (W == 16) ? "rand16" : "rand32";
         sent = 0;
         got  = 0;
         cyc  = 0;
         rbus.in_valid  = 1'b0;
         rbus.a         = '0;
         rbus.b         = '0;
         rbus.is_signed = 1'b0;
         rbus.out_ready = 1'b0;
         wait (rst_r === 1'b0);
         @(negedge clk);
         while (got < NRAND && cyc < RAND_LIMIT) begin
            rbus.in_valid  = (sent < NRAND) && ($urandom_range(3) != 0);
            rbus.a         = W'($urandom);
            rbus.b         = W'($urandom);
            if ($urandom_range(7) == 0) rbus.a = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(7) == 0) rbus.b = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(15) == 0) rbus.a = '1;
            rbus.is_signed = 1'($urandom_range(1));
            rbus.out_ready = ($urandom_range(2) != 0);
            #1;
            acc = rbus.in_valid && rbus.in_ready;
            con = rbus.out_valid && rbus.out_ready;
            if (con) begin
               if (expq.size() == 0) begin
                  check({tag, "_unexpected_output"}, 64'd1, 64'd0);
               end else begin
                  exp_v = expq.pop_front();
                  check(tag, 64'(rbus.out_p), exp_v);
                  got++;
               end
            end
            if (acc) begin
               expq.push_back(ref_mul(32'(rbus.a), 32'(rbus.b), W, rbus.is_signed));
               sent++;
            end
            @(negedge clk);
            cyc++;
         end
         check({tag, "_result_count"}, 64'(got), 64'(NRAND));
         done[gi] = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
